unidade_controle: RTL

//  Moore FSM that sequences fluxo_dados for the music-memory game.
//  - Scrolls the intro message, latches the chosen song, then runs rounds.
//  - Each round plays notes 0..limite, then checks the player's presses with timeout.
//  - Counts errors, updates the score, and declares win or loss.
//  - Also drives the 2-bit display scan index contagem_display.

---
 rtl/sinfonia_pkg.sv | 107 ++++++++++
 rtl/unidade_controle_varredura_display.sv | 27 ++
 rtl/unidade_controle.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sinfonia_pkg.sv
// rtl/sinfonia_pkg.sv - state codes and Moore output decode for the sinfonia game controller
package sinfonia_pkg;

    // Codes are also decoded by the top-level debug display, so keep them stable.
    typedef enum logic [4:0] {
        INICIAL     = 5'd0,
        PREP_MSG    = 5'd1,
        MENSAGEM    = 5'd2,
        ESCOLHE     = 5'd3,
        REG_MUSICA  = 5'd4,
        PREP_JOGO   = 5'd5,
        INI_RODADA  = 5'd6,
        LE_MEM      = 5'd7,
        TOCA        = 5'd8,
        PROX_NOTA   = 5'd9,
        FIM_TOCA    = 5'd10,
        ESPERA      = 5'd11,
        REGISTRA    = 5'd12,
        COMPARA     = 5'd13,
        PROX_JOGADA = 5'd14,
        ERRO        = 5'd15,
        CALCULA     = 5'd16,
        PROX_RODADA = 5'd17,
        GANHOU      = 5'd18,
        PERDEU      = 5'd19
    } estado_t;

    typedef struct packed {
        logic zera_timer_msg;
        logic zera_contador_msg;
        logic enable_timer_msg;
        logic zera_contador_rodada;
        logic zera_contador_jogada;
        logic enable_contador_rodada;
        logic enable_contador_jogada;
        logic enable_registrador_musica;
        logic zera_registrador_botoes;
        logic enable_registrador_botoes;
        logic zera_timeout_buzzer;
        logic conta_timeout_buzzer;
        logic contaT;
        logic zeraT;
        logic contaErro;
        logic zeraErro;
        logic zeraPontos;
        logic calcular;
        logic regPontos;
        logic mostraJ;
        logic mostraB;
        logic select_letra;
        logic sel_memoria_arduino;
        logic activateArduino;
        logic ganhou;
        logic perdeu;
        logic pronto;
    } ctrl_t;

    function automatic ctrl_t decode_saidas(input estado_t e);
        ctrl_t c;
        c = '0;
        case (e)
            INICIAL:     c.pronto = 1'b1;
            PREP_MSG:    begin c.zera_timer_msg = 1'b1; c.zera_contador_msg = 1'b1; end
            MENSAGEM:    c.enable_timer_msg = 1'b1;
            ESCOLHE:     c.mostraB = 1'b1;
            REG_MUSICA:  c.enable_registrador_musica = 1'b1;
            PREP_JOGO: begin
                c.zera_contador_rodada    = 1'b1;
                c.zera_contador_jogada    = 1'b1;
                c.zeraErro                = 1'b1;
                c.zeraPontos              = 1'b1;
                c.zera_registrador_botoes = 1'b1;
            end
            INI_RODADA:  begin c.zera_contador_jogada = 1'b1; c.zera_timeout_buzzer = 1'b1; end
            TOCA: begin
                c.mostraJ              = 1'b1;
                c.sel_memoria_arduino  = 1'b1;
                c.activateArduino      = 1'b1;
                c.select_letra         = 1'b1;
                c.conta_timeout_buzzer = 1'b1;
            end
            PROX_NOTA:   begin c.enable_contador_jogada = 1'b1; c.zera_timeout_buzzer = 1'b1; end
            FIM_TOCA: begin
                c.zera_contador_jogada    = 1'b1;
                c.zeraT                   = 1'b1;
                c.zera_registrador_botoes = 1'b1;
            end
            // Player turn: the buzzer follows the buttons, not the song ROM.
            ESPERA: begin
                c.contaT          = 1'b1;
                c.mostraB         = 1'b1;
                c.activateArduino = 1'b1;
                c.select_letra    = 1'b1;
            end
            REGISTRA:    c.enable_registrador_botoes = 1'b1;
            PROX_JOGADA: begin c.enable_contador_jogada = 1'b1; c.zeraT = 1'b1; end
            ERRO:        c.contaErro = 1'b1;
            CALCULA:     begin c.calcular = 1'b1; c.regPontos = 1'b1; end
            PROX_RODADA: begin c.enable_contador_rodada = 1'b1; c.zeraErro = 1'b1; end
            GANHOU:      begin c.ganhou = 1'b1; c.pronto = 1'b1; end
            PERDEU:      begin c.perdeu = 1'b1; c.pronto = 1'b1; end
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unidade_controle_varredura_display.sv
// rtl/unidade_controle_varredura_display.sv - free-running prescaler and 2-bit display scan counter
module varredura_display #(
    parameter int DISP_DIV = 50
) (
    input  logic       clock,
    input  logic       reset,
    output logic [1:0] contagem_display
);

    localparam int PW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DISP_DIV - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc            <= '0;
            contagem_display <= 2'd0;
        end else if (presc == TERM) begin
            presc            <= '0;
            contagem_display <= contagem_display + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - Moore sequencer for the music-memory game datapath (fluxo_dados)
module unidade_controle
    import sinfonia_pkg::*;
#(
    parameter int MAX_ERROS  = 3,
    parameter int MSG_PASSOS = 21,
    parameter int DISP_DIV   = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       tem_jogada,
    input  logic       botoesIgualMemoria,
    input  logic       enderecoIgualLimite,
    input  logic       fimL,
    input  logic       timeout,
    input  logic       muda_nota,
    input  logic       timeout_contador_msg,
    output logic       zera_timer_msg,
    output logic       zera_contador_msg,
    output logic       enable_timer_msg,
    output logic       enable_contador_msg,
    output logic       zera_contador_rodada,
    output logic       zera_contador_jogada,
    output logic       enable_contador_rodada,
    output logic       enable_contador_jogada,
    output logic       enable_registrador_musica,
    output logic       zera_registrador_botoes,
    output logic       enable_registrador_botoes,
    output logic       zera_timeout_buzzer,
    output logic       conta_timeout_buzzer,
    output logic       contaT,
    output logic       zeraT,
    output logic       contaErro,
    output logic       zeraErro,
    output logic       zeraPontos,
    output logic       calcular,
    output logic       regPontos,
    output logic       mostraJ,
    output logic       mostraB,
    output logic       select_letra,
    output logic       sel_memoria_arduino,
    output logic       activateArduino,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic [1:0] contagem_display,
    output logic [4:0] db_estado
);

    localparam logic [4:0] MSG_ULT = 5'(MSG_PASSOS - 1);
    localparam logic [4:0] ERR_LIM = 5'(MAX_ERROS);

    estado_t    estado;
    estado_t    nxt;
    ctrl_t      saidas;
    logic [3:0] err_cnt;
    logic [4:0] msg_cnt;
    logic [4:0] err_inc;

    assign err_inc = {1'b0, err_cnt} + 5'd1;

    always_comb begin
        nxt = estado;
        case (estado)
            INICIAL:     if (iniciar) nxt = PREP_MSG;
            PREP_MSG:    nxt = MENSAGEM;
            MENSAGEM:    if (timeout_contador_msg && (msg_cnt == MSG_ULT)) nxt = ESCOLHE;
            ESCOLHE:     if (tem_jogada) nxt = REG_MUSICA;
            REG_MUSICA:  nxt = PREP_JOGO;
            PREP_JOGO:   nxt = INI_RODADA;
            INI_RODADA:  nxt = LE_MEM;
            LE_MEM:      nxt = TOCA;
            TOCA:        if (muda_nota) nxt = enderecoIgualLimite ? FIM_TOCA : PROX_NOTA;
            PROX_NOTA:   nxt = LE_MEM;
            FIM_TOCA:    nxt = ESPERA;
            // A press that lands with the timeout still counts as a press.
            ESPERA: begin
                if (tem_jogada)   nxt = REGISTRA;
                else if (timeout) nxt = ERRO;
            end
            REGISTRA:    nxt = COMPARA;
            COMPARA: begin
                if (!botoesIgualMemoria)      nxt = ERRO;
                else if (enderecoIgualLimite) nxt = CALCULA;
                else                          nxt = PROX_JOGADA;
            end
            PROX_JOGADA: nxt = ESPERA;
            ERRO:        nxt = (err_inc == ERR_LIM) ? PERDEU : INI_RODADA;
            CALCULA:     nxt = fimL ? GANHOU : PROX_RODADA;
            PROX_RODADA: nxt = INI_RODADA;
            GANHOU,
            PERDEU:      if (iniciar) nxt = ESCOLHE;
            default:     nxt = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= INICIAL;
            saidas  <= '0;
            err_cnt <= 4'd0;
            msg_cnt <= 5'd0;
        end else begin
            estado <= nxt;
            saidas <= decode_saidas(nxt);
            case (estado)
                PREP_MSG:  msg_cnt <= 5'd0;
                MENSAGEM:  if (timeout_contador_msg) msg_cnt <= msg_cnt + 5'd1;
                PREP_JOGO,
                PROX_RODADA: err_cnt <= 4'd0;
                ERRO:      if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
                default:   ;
            endcase
        end
    end

    assign enable_contador_msg       = (estado == MENSAGEM) && timeout_contador_msg;
    assign zera_timer_msg            = saidas.zera_timer_msg;
    assign zera_contador_msg         = saidas.zera_contador_msg;
    assign enable_timer_msg          = saidas.enable_timer_msg;
    assign zera_contador_rodada      = saidas.zera_contador_rodada;
    assign zera_contador_jogada      = saidas.zera_contador_jogada;
    assign enable_contador_rodada    = saidas.enable_contador_rodada;
    assign enable_contador_jogada    = saidas.enable_contador_jogada;
    assign enable_registrador_musica = saidas.enable_registrador_musica;
    assign zera_registrador_botoes   = saidas.zera_registrador_botoes;
    assign enable_registrador_botoes = saidas.enable_registrador_botoes;
    assign zera_timeout_buzzer       = saidas.zera_timeout_buzzer;
    assign conta_timeout_buzzer      = saidas.conta_timeout_buzzer;
    assign contaT                    = saidas.contaT;
    assign zeraT                     = saidas.zeraT;
    assign contaErro                 = saidas.contaErro;
    assign zeraErro                  = saidas.zeraErro;
    assign zeraPontos                = saidas.zeraPontos;
    assign calcular                  = saidas.calcular;
    assign regPontos                 = saidas.regPontos;
    assign mostraJ                   = saidas.mostraJ;
    assign mostraB                   = saidas.mostraB;
    assign select_letra              = saidas.select_letra;
    assign sel_memoria_arduino       = saidas.sel_memoria_arduino;
    assign activateArduino           = saidas.activateArduino;
    assign ganhou                    = saidas.ganhou;
    assign perdeu                    = saidas.perdeu;
    assign pronto                    = saidas.pronto;
    assign db_estado                 = estado;

    varredura_display #(
        .DISP_DIV(DISP_DIV)
    ) u_varredura (
        .clock            (clock),
        .reset            (reset),
        .contagem_display (contagem_display)
    );

endmodule
